count_sequencer: RTL and testbench

//   Control stage directly upstream of the 4-bit binary counter: drives its Load/Count/Data_in and consumes its C_out.

---
 rtl/count_sequencer_pkg.sv | 19 +
 rtl/count_sequencer_if.sv | 34 +++
 rtl/count_sequencer_prescale_divider.sv | 33 +++
 rtl/count_sequencer.sv | 100 ++++++++++
 tb/tb_count_sequencer.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/count_sequencer_pkg.sv
// Shared types and constants for the count_sequencer interval timer.
// Also supplies the default counter width, which matches the downstream
// 4-bit binary counter.
package count_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    PAUSE = 2'd3
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  localparam int DFLT_DATA_WIDTH     = 4;
  localparam int DFLT_PRESCALE_WIDTH = 8;

endpackage

// File: rtl/count_sequencer_if.sv
// Control bus between the timer host, count_sequencer and the counter.
//   start/stop/pause/mode/period/prescale : host -> sequencer
//   cnt_carry                             : counter C_out -> sequencer
//   cnt_load/cnt_count/cnt_data           : sequencer -> counter
//   tick/busy                             : sequencer status
// The slave modport is the sequencer; the master modport is everything
// around it (host plus counter).
interface count_sequencer_if #(
  parameter int DATA_WIDTH     = count_sequencer_pkg::DFLT_DATA_WIDTH,
  parameter int PRESCALE_WIDTH = count_sequencer_pkg::DFLT_PRESCALE_WIDTH
);
  logic                      start;
  logic                      stop;
  logic                      pause;
  logic                      mode;
  logic [DATA_WIDTH-1:0]     period;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic                      cnt_carry;
  logic                      cnt_load;
  logic                      cnt_count;
  logic [DATA_WIDTH-1:0]     cnt_data;
  logic                      tick;
  logic                      busy;

  modport slave (
    input  start, stop, pause, mode, period, prescale, cnt_carry,
    output cnt_load, cnt_count, cnt_data, tick, busy
  );

  modport master (
    output start, stop, pause, mode, period, prescale, cnt_carry,
    input  cnt_load, cnt_count, cnt_data, tick, busy
  );
endinterface

// File: rtl/count_sequencer_prescale_divider.sv
// Prescale divider: counts enabled cycles and asserts o_strobe when the
// count equals i_limit, then wraps to 0, so strobes come every i_limit+1
// enabled cycles. i_clr has priority over i_en.
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_clr          : restart count at 0
//   i_en           : advance count
//   i_limit        : terminal count
//   o_strobe       : count == limit (combinational)
module count_sequencer_prescale_divider #(
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_clr,
  input  logic                      i_en,
  input  logic [PRESCALE_WIDTH-1:0] i_limit,
  output logic                      o_strobe
);
  logic [PRESCALE_WIDTH-1:0] r_cnt;
  logic                      w_hit;

  assign w_hit    = (r_cnt == i_limit);
  assign o_strobe = w_hit;

  // Wrapping happens only through the strobe reset, so r_cnt never passes
  // i_limit while the limit is held constant by the caller.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)   r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= w_hit ? '0 : r_cnt + 1'b1;
  end
endmodule

// File: rtl/count_sequencer.sv
// count_sequencer: drives a binary up-counter as a programmable interval
// timer. On Start it loads the counter with (all-ones - Period) so that
// C_out rises after Period prescaled steps; the following cycle raises a
// one-cycle tick and either reloads (periodic) or returns to IDLE.
// Ports:
//   i_clk   : clock
//   i_clear : synchronous active-low reset
//   bus     : count_sequencer_if.slave (host controls, counter link, status)
module count_sequencer
  import count_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH     = DFLT_DATA_WIDTH,
  parameter int PRESCALE_WIDTH = DFLT_PRESCALE_WIDTH
) (
  input  logic               i_clk,
  input  logic               i_clear,
  count_sequencer_if.slave   bus
);
  localparam logic [DATA_WIDTH-1:0] CNT_MAX = {DATA_WIDTH{1'b1}};

  state_t                    r_state;
  logic                      r_mode;
  logic [DATA_WIDTH-1:0]     r_period;
  logic [PRESCALE_WIDTH-1:0] r_prescale;
  logic                      r_tick;

  logic w_strobe;
  logic w_run;

  assign w_run = (r_state == RUN);

  // The divider runs on every RUN cycle, including the one where Pause is
  // first seen; only the PAUSE state itself freezes it, so a Pause held N
  // cycles delays the period by exactly N cycles.
  count_sequencer_prescale_divider #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_div (
    .i_clk    (i_clk),
    .i_rst_n  (i_clear),
    .i_clr    (r_state == LOAD),
    .i_en     (w_run),
    .i_limit  (r_prescale),
    .o_strobe (w_strobe)
  );

  always_ff @(posedge i_clk) begin
    if (!i_clear) begin
      r_state    <= IDLE;
      r_mode     <= MODE_ONESHOT;
      r_period   <= '0;
      r_prescale <= '0;
      r_tick     <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start && (bus.period != '0)) begin
            r_mode     <= bus.mode;
            r_period   <= bus.period;
            r_prescale <= bus.prescale;
            r_state    <= LOAD;
          end
        end
        LOAD: begin
          r_state <= bus.stop ? IDLE : RUN;
        end
        RUN: begin
          if (bus.stop)           r_state <= IDLE;
          else if (bus.pause)     r_state <= PAUSE;
          else if (bus.cnt_carry) begin
            r_tick  <= 1'b1;
            r_state <= (r_mode == MODE_PERIODIC) ? LOAD : IDLE;
          end
        end
        PAUSE: begin
          if (bus.stop)       r_state <= IDLE;
          else if (!bus.pause) r_state <= RUN;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Counter controls are decoded from state; Cnt_data is zero outside LOAD
  // so every output reads 0 in reset/IDLE.
  always_comb begin
    bus.cnt_load  = 1'b0;
    bus.cnt_data  = '0;
    bus.cnt_count = 1'b0;
    if (r_state == LOAD) begin
      bus.cnt_load = 1'b1;
      bus.cnt_data = CNT_MAX - r_period;
    end
    // Hold the counter at all-ones once carry is up so C_out stays stable.
    if (w_run) bus.cnt_count = w_strobe & ~bus.cnt_carry;
  end

  assign bus.tick = r_tick;
  assign bus.busy = (r_state != IDLE);
endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer with a behavioural 4-bit counter attached.
// Expected Tick cycles go into a scoreboard queue when a run is started
// and are popped by a monitor whenever Tick is seen.
module tb_count_sequencer;
  logic clk = 1'b0;
  logic clear;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_q[$];
  logic [3:0] cnt_q;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  count_sequencer_if #(.DATA_WIDTH(4), .PRESCALE_WIDTH(8)) bus();

  count_sequencer #(.DATA_WIDTH(4), .PRESCALE_WIDTH(8)) u_dut (
    .i_clk   (clk),
    .i_clear (clear),
    .bus     (bus)
  );

  // Downstream 4-bit counter
  always @(posedge clk) begin
    if (!clear)            cnt_q <= 4'd0;
    else if (bus.cnt_load) cnt_q <= bus.cnt_data;
    else if (bus.cnt_count) cnt_q <= cnt_q + 4'd1;
  end
  assign bus.cnt_carry = (cnt_q == 4'hF);

  // Tick monitor / scoreboard
  always @(negedge clk) begin
    if (bus.tick === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL tick_unexpected: tick at cycle %0d, none required", cyc);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (cyc !== e) begin
          n_bad++;
          $display("FAIL tick_time: tick at cycle %0d, required %0d", cyc, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && exp_q.size() != 0; i++) step();
    repeat (3) step();
  endtask

  task automatic idle_inputs();
    bus.start = 0; bus.stop = 0; bus.pause = 0; bus.mode = 0;
    bus.period = 4'd0; bus.prescale = 8'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    clear = 0;
    step(); step();
    n_cmp++;
    if ({bus.busy, bus.tick, bus.cnt_load, bus.cnt_count} !== 4'b0 || bus.cnt_data !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: busy/tick/load/count=%b data=%0d, required 0000/0",
               {bus.busy, bus.tick, bus.cnt_load, bus.cnt_count}, bus.cnt_data);
    end
    clear = 1;
    step();
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: busy=%b, required 0", bus.busy);
    end
  endtask

  task automatic test_oneshot();
    int k;
    k = cyc;
    bus.start = 1; bus.mode = 0; bus.period = 4'd3; bus.prescale = 8'd0;
    exp_q.push_back(k + 6);
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i == 1) begin
        bus.start = 0;
        n_cmp++;
        if (bus.cnt_load !== 1'b1 || bus.cnt_data !== 4'd12) begin
          n_bad++;
          $display("FAIL oneshot_load: load=%b data=%0d, required 1/12", bus.cnt_load, bus.cnt_data);
        end
      end
      if (i >= 2 && i <= 5) begin
        n_cmp++;
        if (cnt_q !== 4'(10 + i) || bus.cnt_count !== (i != 5)) begin
          n_bad++;
          $display("FAIL oneshot_count: c%0d cnt=%0d count=%b, required %0d/%b",
                   i, cnt_q, bus.cnt_count, 10 + i, (i != 5));
        end
      end
      if (i == 6) begin
        n_cmp++;
        if (bus.busy !== 1'b0) begin
          n_bad++;
          $display("FAIL oneshot_busy_end: busy=%b, required 0", bus.busy);
        end
      end
    end
    drain();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL oneshot_ticks: %0d ticks missing, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_periodic();
    int k;
    k = cyc;
    bus.start = 1; bus.mode = 1; bus.period = 4'd2; bus.prescale = 8'd2;
    for (int p = 1; p <= 4; p++) exp_q.push_back(k + 1 + 8 * p);
    for (int i = 1; i <= 34; i++) begin
      step();
      if (i == 1) begin
        bus.start = 0;
        bus.period = 4'd7; bus.prescale = 8'd0;  // mid-run changes must not matter
      end
      if (i >= 2 && i <= 8) begin
        n_cmp++;
        if (bus.cnt_count !== (i == 4 || i == 7)) begin
          n_bad++;
          $display("FAIL periodic_strobe: c%0d count=%b, required %b", i, bus.cnt_count, (i == 4 || i == 7));
        end
      end
      if (i == 33) bus.stop = 1;
      if (i == 34) begin
        bus.stop = 0;
        n_cmp++;
        if (bus.busy !== 1'b0) begin
          n_bad++;
          $display("FAIL periodic_stop: busy=%b, required 0", bus.busy);
        end
      end
    end
    drain();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL periodic_ticks: %0d ticks missing, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_pause();
    int k;
    k = cyc;
    bus.start = 1; bus.mode = 1; bus.period = 4'd2; bus.prescale = 8'd2;
    exp_q.push_back(k + 9);
    exp_q.push_back(k + 22);
    exp_q.push_back(k + 30);
    exp_q.push_back(k + 38);
    for (int i = 1; i <= 39; i++) begin
      step();
      if (i == 1)  bus.start = 0;
      if (i == 12) bus.pause = 1;
      if (i == 17) bus.pause = 0;
      if (i == 15) begin
        n_cmp++;
        if (bus.cnt_count !== 1'b0 || bus.busy !== 1'b1) begin
          n_bad++;
          $display("FAIL pause_hold: count=%b busy=%b, required 0/1", bus.cnt_count, bus.busy);
        end
      end
      if (i == 38) bus.stop = 1;
      if (i == 39) bus.stop = 0;
    end
    drain();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL pause_ticks: %0d ticks missing, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_stop_start();
    bus.start = 1; bus.mode = 1; bus.period = 4'd2; bus.prescale = 8'd2;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 1) bus.start = 0;
      if (i == 5) begin bus.stop = 1; bus.start = 1; end
      if (i == 6) begin
        bus.stop = 0; bus.start = 0;
        n_cmp++;
        if (bus.busy !== 1'b0) begin
          n_bad++;
          $display("FAIL stop_start_idle: busy=%b, required 0", bus.busy);
        end
      end
      if (i == 8) begin
        n_cmp++;
        if (bus.busy !== 1'b0) begin
          n_bad++;
          $display("FAIL stop_start_norestart: busy=%b, required 0", bus.busy);
        end
      end
    end
    bus.start = 1; bus.mode = 0; bus.period = 4'd0;
    step();
    bus.start = 0;
    step();
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL period_zero: busy=%b, required 0", bus.busy);
    end
    drain();
  endtask

  task automatic test_clear_on_carry();
    int k;
    bus.start = 1; bus.mode = 0; bus.period = 4'd3; bus.prescale = 8'd0;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i == 1) bus.start = 0;
      if (i == 5) begin
        n_cmp++;
        if (bus.cnt_carry !== 1'b1) begin
          n_bad++;
          $display("FAIL clear_carry_setup: carry=%b, required 1", bus.cnt_carry);
        end
        clear = 0;
      end
      if (i == 6) begin
        clear = 1;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.tick !== 1'b0) begin
          n_bad++;
          $display("FAIL clear_abort: busy=%b tick=%b, required 0/0", bus.busy, bus.tick);
        end
      end
    end
    step();
    k = cyc;
    bus.start = 1; bus.mode = 0; bus.period = 4'd5; bus.prescale = 8'd1;
    exp_q.push_back(k + 5 * 2 + 3);
    step();
    bus.start = 0;
    n_cmp++;
    if (bus.cnt_load !== 1'b1 || bus.cnt_data !== 4'd10) begin
      n_bad++;
      $display("FAIL clear_restart_load: load=%b data=%0d, required 1/10", bus.cnt_load, bus.cnt_data);
    end
    drain();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL clear_restart_tick: %0d ticks missing, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_pause();
    test_stop_start();
    test_clear_on_carry();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
